// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int BCD_MAX = 9;
    localparam int BCD_ADJ = 6;

endpackage

// File: rtl/bcd_digit_cell.sv
// Combinational single-digit BCD add with decimal adjust.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] digit,
    output logic               co
);

    localparam int T_W = DIGIT_W + 1;

    logic [T_W-1:0] t;

    // Binary sum reaches at most 19; anything above 9 wraps by adding 6.
    always_comb begin
        t     = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
        co    = (t > T_W'(BCD_MAX));
        digit = co ? DIGIT_W'(t + T_W'(BCD_ADJ)) : t[DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock through a shared digit cell.
// Define BCD_CHECK_EN to flag operands containing digits above 9 on err.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*DIGITS-1:0] sum,
    output logic                    cout,
    output logic                    err
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic               c;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               accept;
    logic [DIGIT_W-1:0] cell_a;
    logic [DIGIT_W-1:0] cell_b;
    logic [DIGIT_W-1:0] cell_d;
    logic               cell_co;

    assign accept = in_valid && (state == IDLE);
    assign cell_a = a_r[DIGIT_W*idx +: DIGIT_W];
    assign cell_b = b_r[DIGIT_W*idx +: DIGIT_W];

    bcd_digit_cell u_cell (
        .a     (cell_a),
        .b     (cell_b),
        .ci    (c),
        .digit (cell_d),
        .co    (cell_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (idx == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Operand holding registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            c      <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c     <= cin;
                        idx   <= '0;
                        sum_r <= '0;
                    end
                end
                RUN: begin
                    sum_r[DIGIT_W*idx +: DIGIT_W] <= cell_d;
                    c <= cell_co;
                    if (idx == LAST) begin
                        cout_r <= cell_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    logic bad_digit;
    logic err_r;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
                (b[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX))) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (accept) begin
            err_r <= bad_digit;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder: directed cases plus randomized operands.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   passed     = 0;
    int   cyc        = 0;
    bit   prev_ov    = 1'b0;
    bit   rand_ready = 1'b0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endfunction

    // Reference: valid operands use plain decimal arithmetic; invalid digits
    // fall back to the per-digit "add, wrap by 6 above nine" rule.
    function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci, output logic [W-1:0] s,
                                    output logic co, output logic e);
        bit      bad = 1'b0;
        longint  dx = 0, dy = 0, tot, scale = 1;
        int      da, db, t, carry;
        for (int i = 0; i < DIGITS; i++) begin
            da = int'(x[4*i +: 4]);
            db = int'(y[4*i +: 4]);
            if (da > 9 || db > 9) bad = 1'b1;
            dx += da * scale;
            dy += db * scale;
            scale *= 10;
        end
        s = '0;
        if (!bad) begin
            tot = dx + dy + longint'(ci);
            co  = (tot >= scale);
            for (int i = 0; i < DIGITS; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            carry = int'(ci);
            for (int i = 0; i < DIGITS; i++) begin
                t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + carry;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    carry = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    carry = 0;
                end
            end
            co = (carry != 0);
        end
`ifdef BCD_CHECK_EN
        e = bad;
`else
        e = 1'b0;
`endif
    endfunction

    // Drive one operand bundle; the expectation is queued just before the accept edge.
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input bit keep, input bit use_const,
                         input logic [W-1:0] es, input logic eco);
        exp_t         e;
        logic [W-1:0] ms;
        logic         mco, merr;
        int           n = 0;
        @(posedge clk);
        #1;
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 100) begin
                check("accept_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        ref_add(xa, xb, xc, ms, mco, merr);
        e.sum  = use_const ? es  : ms;
        e.cout = use_const ? eco : mco;
        e.err  = merr;
        e.acc  = cyc + 1;
        if (keep) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Monitor: latency at the rise of out_valid, data at each output handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) check("ready_while_valid", 64'(in_ready), 64'd0);
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) check("unexpected_output", 64'd0, 64'd1);
                else check("latency", 64'(cyc + 1 - exp_q[0].acc), 64'(DIGITS + 1));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", 64'd0, 64'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                    check("err", 64'(err), 64'(e.err));
                end
            end
            prev_ov = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        out_ready = 1'b1;
        issue(16'h1234, 16'h5678, 1'b0, 1, 1, 16'h6912, 1'b0);
        issue(16'h9999, 16'h0000, 1'b1, 1, 1, 16'h0000, 1'b1);
        issue(16'h9999, 16'h9999, 1'b1, 1, 1, 16'h9999, 1'b1);
        drain();

        // Back-pressure with a second bundle waiting during DONE.
        out_ready = 1'b0;
        issue(16'h4567, 16'h4444, 1'b0, 1, 1, 16'h9011, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum_hold", 64'(sum), 64'h9011);
            check("bp_cout_hold", 64'(cout), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_no_accept", 64'(in_ready), 64'd0);
        exp_q.push_back('{sum: 16'h0303, cout: 1'b0, err: 1'b0, acc: cyc + 2});
        @(negedge clk);
        check("bp_idle_after_handshake", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Abort mid-RUN: reset while digit 2 is being processed.
        issue(16'h1111, 16'h2222, 1'b0, 0, 0, '0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        issue(16'h0001, 16'h0009, 1'b0, 1, 1, 16'h0010, 1'b0);
        drain();

        // Invalid digit handling (err depends on BCD_CHECK_EN).
        issue(16'h12A4, 16'h0000, 1'b0, 1, 0, '0, 1'b0);
        issue(16'h1234, 16'h0000, 1'b0, 1, 0, '0, 1'b0);
        drain();

        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bit allow_bad;
            allow_bad = ($urandom_range(0, 7) == 0);
            issue(rand_operand(allow_bad), rand_operand(allow_bad), 1'($urandom),
                  1, 0, '0, 1'b0);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
